// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: read-tracking
// states, port identifiers and a port-to-one-hot helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_IF = 2'd1,
    RD_DM = 2'd2
  } state_e;

  // Grant vectors use bit 0 for the fetch port and bit 1 for the data port.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  function automatic logic [1:0] port_onehot(input logic port);
    return (port == PORT_DM) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// port that did not win last time.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = req_i;
    if (req_i == 2'b11) begin
      gnt_o = port_onehot(~last_grant_i);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between an instruction-fetch port and a data
// port; grants in the request cycle, read data returns one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [ADDR_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  stall_o
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;
  logic [1:0]            arb_gnt, gnt;

  rr_arb2 u_rr_arb2 (
    .req_i        ({dm_req_i, if_req_i}),
    .last_grant_i (last_grant_q),
    .gnt_o        (arb_gnt)
  );

  // Grants are combinational, so they are masked while reset is held.
  assign gnt      = arb_gnt & {2{rst}};
  assign if_gnt_o = gnt[0];
  assign dm_gnt_o = gnt[1];

  assign mem_en_o    = |gnt;
  assign mem_we_o    = gnt[1] & dm_we_i;
  assign mem_addr_o  = gnt[1] ? dm_addr_i : if_addr_i;
  assign mem_wdata_o = dm_wdata_i;

  assign stall_o = (if_req_i & ~gnt[0]) | (dm_req_i & ~gnt[1]);

  always_comb begin
    state_d      = IDLE;
    last_grant_d = last_grant_q;
    if (gnt[0]) begin
      state_d      = RD_IF;
      last_grant_d = PORT_IF;
    end else if (gnt[1]) begin
      state_d      = dm_we_i ? IDLE : RD_DM;
      last_grant_d = PORT_DM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= PORT_DM;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (state_q == RD_IF) if_rdata_q <= mem_rdata_i;
      if (state_q == RD_DM) dm_rdata_q <= mem_rdata_i;
    end
  end

  // Memory data is live in the response cycle; the register keeps it afterwards.
  assign if_rvalid_o = (state_q == RD_IF);
  assign dm_rvalid_o = (state_q == RD_DM);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
  assign dm_rdata_o  = dm_rvalid_o ? mem_rdata_i : dm_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios followed by random traffic, checked cycle by cycle
// against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_en, mem_we, stall;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
    .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
    .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
    .dm_gnt_o(dm_gnt), .dm_rvalid_o(dm_rvalid), .dm_rdata_o(dm_rdata),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata), .stall_o(stall)
  );

  // Behavioural single-port memory: one-cycle read latency, junk otherwise.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[5:0]];
    else                   mem_rdata <= $urandom;
    if (mem_en && mem_we)  mem[mem_addr[5:0]] <= mem_wdata;
  end

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [0:63];
  int          m_last;       // 0 = fetch won last, 1 = data won last
  int          m_pend;       // 0 none, 1 fetch read due, 2 data read due
  logic [31:0] m_pend_data, m_if_hold, m_dm_hold;
  logic        last_if_g, last_dm_g;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic do_cycle();
    logic eg_if, eg_dm, erv_if, erv_dm;
    if (!rst) begin
      m_last = 1; m_pend = 0; m_if_hold = 0; m_dm_hold = 0;
    end
    if (!rst)                  begin eg_if = 0; eg_dm = 0; end
    else if (if_req && dm_req) begin eg_if = (m_last == 1); eg_dm = !eg_if; end
    else                       begin eg_if = if_req; eg_dm = dm_req; end
    erv_if = (m_pend == 1);
    erv_dm = (m_pend == 2);
    if (erv_if) m_if_hold = m_pend_data;
    if (erv_dm) m_dm_hold = m_pend_data;
    #3;
    $display("t=%0t rst=%0b req=%0b%0b gnt=%0b%0b rv=%0b%0b en=%0b we=%0b stall=%0b",
             $time, rst, if_req, dm_req, if_gnt, dm_gnt, if_rvalid, dm_rvalid, mem_en, mem_we, stall);
    chk("if_gnt", {31'd0, if_gnt}, {31'd0, eg_if});
    chk("dm_gnt", {31'd0, dm_gnt}, {31'd0, eg_dm});
    chk("mem_en", {31'd0, mem_en}, {31'd0, eg_if | eg_dm});
    chk("mem_we", {31'd0, mem_we}, {31'd0, eg_dm & dm_we});
    if (eg_if) chk("mem_addr_if", mem_addr, if_addr);
    if (eg_dm) chk("mem_addr_dm", mem_addr, dm_addr);
    if (eg_dm && dm_we) chk("mem_wdata", mem_wdata, dm_wdata);
    chk("stall", {31'd0, stall}, {31'd0, (if_req & !eg_if) | (dm_req & !eg_dm)});
    chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, erv_if});
    chk("dm_rvalid", {31'd0, dm_rvalid}, {31'd0, erv_dm});
    chk("if_rdata", if_rdata, m_if_hold);
    chk("dm_rdata", dm_rdata, m_dm_hold);
    last_if_g = eg_if;
    last_dm_g = eg_dm;
    @(posedge clk);
    m_pend = 0;
    if (rst) begin
      if (eg_if) begin
        m_last = 0; m_pend = 1; m_pend_data = ref_mem[if_addr[5:0]];
      end else if (eg_dm) begin
        m_last = 1;
        if (dm_we) ref_mem[dm_addr[5:0]] = dm_wdata;
        else begin m_pend = 2; m_pend_data = ref_mem[dm_addr[5:0]]; end
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      mem[i]     = ref_mem[i];
    end
    ref_mem[0] = 32'h0050_0093;
    mem[0]     = 32'h0050_0093;
    m_last = 1; m_pend = 0; m_pend_data = 0; m_if_hold = 0; m_dm_hold = 0;
    rst = 1'b0; if_req = 0; if_addr = 0; dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
    @(posedge clk); #1;
    do_cycle(); do_cycle();
    rst = 1'b1;

    // Fetch-only read of address 0
    if_req = 1; if_addr = 32'h0; do_cycle();
    if_req = 0; do_cycle();

    // Contention straight out of reset: fetch first, then data
    rst = 0; do_cycle(); rst = 1;
    if_req = 1; if_addr = 32'h4; dm_req = 1; dm_we = 0; dm_addr = 32'h8; do_cycle();
    if_req = 0; do_cycle();
    dm_req = 0; do_cycle();

    // Data write then read it back through the fetch port
    dm_req = 1; dm_we = 1; dm_addr = 32'h10; dm_wdata = 32'hDEAD_BEEF; do_cycle();
    dm_req = 0; dm_we = 0; if_req = 1; if_addr = 32'h10; do_cycle();
    if_req = 0; do_cycle();

    // Both ports held for six cycles: strict alternation
    if_req = 1; if_addr = 32'h14; dm_req = 1; dm_we = 0; dm_addr = 32'h18;
    for (int i = 0; i < 6; i++) do_cycle();
    if_req = 0; dm_req = 0; do_cycle();

    // Idle for three cycles
    for (int i = 0; i < 3; i++) do_cycle();

    // Reset lands while a fetch read is outstanding
    if_req = 1; if_addr = 32'h1C; do_cycle();
    rst = 0; if_req = 0; do_cycle();
    if_req = 1; dm_req = 1; do_cycle();
    rst = 1; do_cycle(); do_cycle();
    if_req = 0; dm_req = 0; do_cycle();

    // Random traffic with stable-until-granted requesters
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 49) != 0);
      if (!if_req || last_if_g) begin
        if_req  = ($urandom_range(0, 3) != 0);
        if_addr = 32'($urandom_range(0, 63));
      end
      if (!dm_req || last_dm_g) begin
        dm_req   = ($urandom_range(0, 2) != 0);
        dm_we    = $urandom_range(0, 1) == 1;
        dm_addr  = 32'($urandom_range(0, 63));
        dm_wdata = $urandom;
      end
      do_cycle();
    end
    rst = 1; if_req = 0; dm_req = 0; do_cycle(); do_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
